// File: rtl/l1_line_ctrl.sv
// Sequencing controller for a bank of single-line L1 units: fully-associative,
// write-through, no-write-allocate, round-robin refill of 8-word lines.
module l1_line_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int PTR_W     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_rreq,
  input  logic                    cpu_wreq,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_stall,
  input  logic                    hit_any,
  input  logic [31:0]             hit_rdata,
  output logic [NUM_LINES-1:0]    line_valid,
  output logic [23*NUM_LINES-1:0] line_tag,
  output logic [4*NUM_LINES-1:0]  line_set,
  output logic [31:0]             line_addr,
  output logic                    line_rreq,
  output logic                    line_wreq,
  output logic [31:0]             line_wdata,
  output logic                    mem_rreq,
  output logic                    mem_wreq,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [2:0]           word_cnt_q, word_cnt_d;
  logic [22:0]          tag_q [NUM_LINES];
  logic [3:0]           set_q [NUM_LINES];
  logic                 latch_en;
  logic [31:0]          fill_addr;

  // The victim's own tag/set registers double as the latched miss address.
  assign fill_addr = {tag_q[ptr_q], set_q[ptr_q], word_cnt_q, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ptr_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    always_ff @(posedge clk) begin
      if (reset) begin
        tag_q[gi] <= '0;
        set_q[gi] <= '0;
      end else if (latch_en && (ptr_q == PTR_W'(gi))) begin
        tag_q[gi] <= cpu_addr[31:9];
        set_q[gi] <= cpu_addr[8:5];
      end
    end
    assign line_tag[23*gi +: 23] = tag_q[gi];
    assign line_set[4*gi +: 4]   = set_q[gi];
  end

  assign line_valid = valid_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    word_cnt_d = word_cnt_q;
    latch_en   = 1'b0;
    cpu_rdata  = '0;
    cpu_stall  = 1'b0;
    line_addr  = cpu_addr;
    line_rreq  = 1'b0;
    line_wreq  = 1'b0;
    line_wdata = '0;
    mem_rreq   = 1'b0;
    mem_wreq   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    // Outputs stay quiet while reset is held so nothing leaks onto the buses.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          line_rreq = cpu_rreq & ~cpu_wreq;
          if (cpu_wreq) begin
            cpu_stall = 1'b1;
            state_d   = WRITE;
          end else if (cpu_rreq) begin
            if (hit_any) begin
              cpu_rdata = hit_rdata;
            end else begin
              cpu_stall        = 1'b1;
              latch_en         = 1'b1;
              valid_d[ptr_q]   = 1'b0;
              word_cnt_d       = '0;
              state_d          = FILL;
            end
          end
        end
        FILL: begin
          cpu_stall = 1'b1;
          mem_rreq  = 1'b1;
          mem_addr  = fill_addr;
          line_addr = fill_addr;
          if (mem_ack) begin
            line_wreq  = 1'b1;
            line_wdata = mem_rdata;
            word_cnt_d = word_cnt_q + 3'd1;
            if (word_cnt_q == 3'd7) begin
              valid_d[ptr_q] = 1'b1;
              ptr_d          = (ptr_q == PTR_W'(NUM_LINES - 1)) ? '0 : ptr_q + 1'b1;
              state_d        = IDLE;
            end
          end
        end
        WRITE: begin
          mem_wreq  = 1'b1;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          cpu_stall = 1'b1;
          if (mem_ack) begin
            cpu_stall  = 1'b0;
            line_wreq  = 1'b1;
            line_wdata = cpu_wdata;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
